jump_sequencer: RTL and testbench

- Multi-cycle controller that runs the 16-bit jump/call instruction sequence around the J register pair (J1 high byte, J2 low byte), the program counter, the incrementer and the XY return register.
- Issues the select and load strobes that drive the control bus.
  - Fetches two operand bytes from memory into J1 and J2, advancing PC after each byte.
  - Then transfers J to PC (the jump), or skips the transfer when the branch condition is false.
  - For a call, also saves the return address into XY.
- Sits between the instruction decoder (start/done handshake) and the register unit control lines.

---
 rtl/jump_sequencer.sv | 147 ++++++++++++++
 tb/tb_jump_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// Control sequencer for the 16-bit jump/call: fetches J1/J2 through PC, optionally
// saves the return address in XY, then loads PC from J when the branch is taken.
module jump_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOAD_CYCLES   = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic is_call,
    input  logic cond_ok,
    output logic busy,
    output logic done,
    output logic sel_pc,
    output logic mem_rd,
    output logic ld_j1,
    output logic ld_j2,
    output logic ld_inc,
    output logic sel_inc,
    output logic ld_pc,
    output logic sel_j,
    output logic ld_xy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH1 = 3'd1;
    localparam logic [2:0] INC1   = 3'd2;
    localparam logic [2:0] FETCH2 = 3'd3;
    localparam logic [2:0] INC2   = 3'd4;
    localparam logic [2:0] JUMP   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [4:0] LAST_CNT = 5'(SETTLE_CYCLES + LOAD_CYCLES - 1);
    localparam logic [5:0] SETTLE   = 6'(SETTLE_CYCLES);

    typedef struct packed {
        logic busy;
        logic done;
        logic sel_pc;
        logic mem_rd;
        logic ld_j1;
        logic ld_j2;
        logic ld_inc;
        logic sel_inc;
        logic ld_pc;
        logic sel_j;
        logic ld_xy;
    } ctl_t;

    logic [2:0] state, nxt_state;
    logic [4:0] cnt, nxt_cnt;
    logic       call_q, cond_q;
    logic       phase_end;
    logic       ld_on;
    ctl_t       ctl_q, nxt_ctl;

    assign phase_end = (cnt == LAST_CNT);

    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 5'd1;
        case (state)
            IDLE:    if (start) nxt_state = FETCH1;
            FETCH1:  if (phase_end) nxt_state = INC1;
            INC1:    if (phase_end) nxt_state = FETCH2;
            FETCH2:  if (phase_end) nxt_state = INC2;
            INC2:    if (phase_end) nxt_state = cond_q ? JUMP : DONE;
            JUMP:    if (phase_end) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        if (nxt_state != state || state == IDLE) nxt_cnt = '0;
    end

    // Outputs are decoded from the next state so they can be registered with no
    // added latency; loads occupy the last LOAD_CYCLES counts of each phase.
    assign ld_on = ({1'b0, nxt_cnt} + 6'd1) > SETTLE;

    always_comb begin
        nxt_ctl      = '0;
        nxt_ctl.busy = (nxt_state != IDLE);
        case (nxt_state)
            FETCH1: begin
                nxt_ctl.sel_pc = 1'b1;
                nxt_ctl.mem_rd = 1'b1;
                nxt_ctl.ld_j1  = ld_on;
                nxt_ctl.ld_inc = ld_on;
            end
            INC1: begin
                nxt_ctl.sel_inc = 1'b1;
                nxt_ctl.ld_pc   = ld_on;
            end
            FETCH2: begin
                nxt_ctl.sel_pc = 1'b1;
                nxt_ctl.mem_rd = 1'b1;
                nxt_ctl.ld_j2  = ld_on;
                nxt_ctl.ld_inc = ld_on;
            end
            INC2: begin
                nxt_ctl.sel_inc = 1'b1;
                nxt_ctl.ld_pc   = ld_on;
                nxt_ctl.ld_xy   = ld_on & call_q;
            end
            JUMP: begin
                nxt_ctl.sel_j = 1'b1;
                nxt_ctl.ld_pc = ld_on;
            end
            DONE:    nxt_ctl.done = 1'b1;
            default: nxt_ctl = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            call_q <= 1'b0;
            cond_q <= 1'b0;
            ctl_q  <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            ctl_q <= nxt_ctl;
            if (state == IDLE && start) begin
                call_q <= is_call;
                cond_q <= cond_ok;
            end
        end
    end

    assign busy    = ctl_q.busy;
    assign done    = ctl_q.done;
    assign sel_pc  = ctl_q.sel_pc;
    assign mem_rd  = ctl_q.mem_rd;
    assign ld_j1   = ctl_q.ld_j1;
    assign ld_j2   = ctl_q.ld_j2;
    assign ld_inc  = ctl_q.ld_inc;
    assign sel_inc = ctl_q.sel_inc;
    assign ld_pc   = ctl_q.ld_pc;
    assign sel_j   = ctl_q.sel_j;
    assign ld_xy   = ctl_q.ld_xy;

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboard bench for jump_sequencer: default-parameter instance plus a
// SETTLE_CYCLES=0 / LOAD_CYCLES=2 instance, checked cycle by cycle.
module tb_jump_sequencer;

    typedef struct {
        int         cyc;
        logic [10:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic is_call = 1'b0;
    logic cond_ok = 1'b0;

    logic busy_a, done_a, sel_pc_a, mem_rd_a, ld_j1_a, ld_j2_a, ld_inc_a, sel_inc_a, ld_pc_a, sel_j_a, ld_xy_a;
    logic busy_b, done_b, sel_pc_b, mem_rd_b, ld_j1_b, ld_j2_b, ld_inc_b, sel_inc_b, ld_pc_b, sel_j_b, ld_xy_b;
    logic [10:0] vec_a, vec_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   done_q_a[$];
    int   done_q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jump_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .is_call(is_call), .cond_ok(cond_ok),
        .busy(busy_a), .done(done_a), .sel_pc(sel_pc_a), .mem_rd(mem_rd_a), .ld_j1(ld_j1_a),
        .ld_j2(ld_j2_a), .ld_inc(ld_inc_a), .sel_inc(sel_inc_a), .ld_pc(ld_pc_a),
        .sel_j(sel_j_a), .ld_xy(ld_xy_a)
    );

    jump_sequencer #(.SETTLE_CYCLES(0), .LOAD_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .is_call(is_call), .cond_ok(cond_ok),
        .busy(busy_b), .done(done_b), .sel_pc(sel_pc_b), .mem_rd(mem_rd_b), .ld_j1(ld_j1_b),
        .ld_j2(ld_j2_b), .ld_inc(ld_inc_b), .sel_inc(sel_inc_b), .ld_pc(ld_pc_b),
        .sel_j(sel_j_b), .ld_xy(ld_xy_b)
    );

    // Vector order: busy done sel_pc mem_rd ld_j1 ld_j2 ld_inc sel_inc ld_pc sel_j ld_xy
    assign vec_a = {busy_a, done_a, sel_pc_a, mem_rd_a, ld_j1_a, ld_j2_a, ld_inc_a, sel_inc_a, ld_pc_a, sel_j_a, ld_xy_a};
    assign vec_b = {busy_b, done_b, sel_pc_b, mem_rd_b, ld_j1_b, ld_j2_b, ld_inc_b, sel_inc_b, ld_pc_b, sel_j_b, ld_xy_b};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Expected outputs in cycle k (1-based) of a sequence with phase length p and
    // settle s: phases FETCH1, INC1, FETCH2, INC2, [JUMP], then a one-cycle DONE.
    function automatic logic [10:0] seq_vec(input int k, input int p, input int s,
                                            input bit taken, input bit call);
        int   nph, ph, off;
        logic ld;
        logic [10:0] v;
        nph = taken ? 5 : 4;
        v   = '0;
        if (k == nph * p + 1) return 11'b110_0000_0000;
        ph = (k - 1) / p;
        off = (k - 1) % p;
        ld = (off >= s);
        v[10] = 1'b1;
        case (ph)
            0: begin v[8] = 1'b1; v[7] = 1'b1; v[6] = ld; v[4] = ld; end
            1: begin v[3] = 1'b1; v[2] = ld; end
            2: begin v[8] = 1'b1; v[7] = 1'b1; v[5] = ld; v[4] = ld; end
            3: begin v[3] = 1'b1; v[2] = ld; v[0] = ld & call; end
            default: begin v[1] = 1'b1; v[2] = ld; end
        endcase
        return v;
    endfunction

    task automatic push_seq(input bit on_b, input int base, input int p, input int s,
                            input bit taken, input bit call, input int max_k, input int done_abs);
        int len;
        exp_t e;
        len = (taken ? 5 : 4) * p + 1;
        for (int k = 1; k <= len && k <= max_k; k++) begin
            e.cyc = base + k;
            e.v   = seq_vec(k, p, s, taken, call);
            if (on_b) exp_b.push_back(e); else exp_a.push_back(e);
        end
        if (done_abs > 0) begin
            if (on_b) done_q_b.push_back(done_abs); else done_q_a.push_back(done_abs);
        end
    endtask

    task automatic push_zero(input bit on_b, input int c);
        exp_t e;
        e.cyc = c;
        e.v   = '0;
        if (on_b) exp_b.push_back(e); else exp_a.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge, independent of stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_a.size() > 0 && exp_a[0].cyc == cyc) begin
                e = exp_a.pop_front();
                check("vec_a", {21'b0, vec_a}, {21'b0, e.v});
            end
            if (exp_b.size() > 0 && exp_b[0].cyc == cyc) begin
                e = exp_b.pop_front();
                check("vec_b", {21'b0, vec_b}, {21'b0, e.v});
            end
            if (done_a) begin
                if (done_q_a.size() == 0) check("done_a_unexpected", 32'd1, 32'd0);
                else check("done_a_cycle", cyc, done_q_a.pop_front());
            end
            if (done_b) begin
                if (done_q_b.size() == 0) check("done_b_unexpected", 32'd1, 32'd0);
                else check("done_b_cycle", cyc, done_q_b.pop_front());
            end
            if (cyc > 1) begin
                check("sel_excl_a", {30'b0, 2'(32'(sel_pc_a) + 32'(sel_inc_a) + 32'(sel_j_a) > 1)}, 32'd0);
                check("sel_excl_b", {30'b0, 2'(32'(sel_pc_b) + 32'(sel_inc_b) + 32'(sel_j_b) > 1)}, 32'd0);
                check("ld_sel_a", {31'b0, ((ld_j1_a | ld_j2_a | ld_inc_a) & ~sel_pc_a) |
                                          (ld_pc_a & ~(sel_inc_a | sel_j_a)) | (ld_xy_a & ~sel_inc_a)}, 32'd0);
                check("ld_sel_b", {31'b0, ((ld_j1_b | ld_j2_b | ld_inc_b) & ~sel_pc_b) |
                                          (ld_pc_b & ~(sel_inc_b | sel_j_b)) | (ld_xy_b & ~sel_inc_b)}, 32'd0);
            end
        end
    end

    // Stimulus: inputs change on falling edges; base is cyc at the falling edge
    // before the edge that samples start, so cycle k is observed at cyc == base+k.
    initial begin
        int base;
        for (int c = 1; c <= 3; c++) begin
            push_zero(1'b0, c);
            push_zero(1'b1, c);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Taken jump, no call: done in cycle 16.
        @(negedge clk);
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b1, 1'b0, 99, base + 16);
        push_zero(1'b0, base + 17);
        push_zero(1'b0, base + 18);
        start_a = 1'b1; cond_ok = 1'b1; is_call = 1'b0;
        @(negedge clk); start_a = 1'b0;
        repeat (19) @(negedge clk);

        // Not-taken call: ld_xy with ld_pc in cycle 12, done in cycle 13.
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b0, 1'b1, 99, base + 13);
        push_zero(1'b0, base + 14);
        push_zero(1'b0, base + 15);
        start_a = 1'b1; cond_ok = 1'b0; is_call = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (16) @(negedge clk);

        // Inputs changed and start re-pulsed in cycle 5 must not disturb the sequence.
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b1, 1'b0, 99, base + 16);
        push_zero(1'b0, base + 17);
        push_zero(1'b0, base + 18);
        start_a = 1'b1; cond_ok = 1'b1; is_call = 1'b0;
        @(negedge clk); start_a = 1'b0;
        repeat (4) @(negedge clk);
        start_a = 1'b1; cond_ok = 1'b0; is_call = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (13) @(negedge clk);

        // Reset during cycle 8 (FETCH2): all zeros from cycle 9.
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b1, 1'b0, 8, 0);
        for (int c = 9; c <= 12; c++) push_zero(1'b0, base + c);
        start_a = 1'b1; cond_ok = 1'b1; is_call = 1'b0;
        @(negedge clk); start_a = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh start after reset runs the full 16-cycle sequence.
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b1, 1'b0, 99, base + 16);
        push_zero(1'b0, base + 17);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (18) @(negedge clk);

        // start held high: done in 16 and 33, one IDLE cycle (17) between.
        base = cyc;
        push_seq(1'b0, base, 3, 2, 1'b1, 1'b0, 99, base + 16);
        push_zero(1'b0, base + 17);
        push_seq(1'b0, base + 17, 3, 2, 1'b1, 1'b0, 99, base + 33);
        push_zero(1'b0, base + 34);
        push_zero(1'b0, base + 35);
        start_a = 1'b1;
        repeat (33) @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);

        // P=2, no settle: taken done in cycle 11.
        base = cyc;
        push_seq(1'b1, base, 2, 0, 1'b1, 1'b0, 99, base + 11);
        push_zero(1'b1, base + 12);
        start_b = 1'b1; cond_ok = 1'b1; is_call = 1'b0;
        @(negedge clk); start_b = 1'b0;
        repeat (13) @(negedge clk);

        // P=2, not-taken call: done in cycle 9.
        base = cyc;
        push_seq(1'b1, base, 2, 0, 1'b0, 1'b1, 99, base + 9);
        push_zero(1'b1, base + 10);
        start_b = 1'b1; cond_ok = 1'b0; is_call = 1'b1;
        @(negedge clk); start_b = 1'b0;
        repeat (12) @(negedge clk);

        check("exp_a_drained", exp_a.size(), 32'd0);
        check("exp_b_drained", exp_b.size(), 32'd0);
        check("done_a_drained", done_q_a.size(), 32'd0);
        check("done_b_drained", done_q_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
